// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - control/datapath bundle for the multicycle RV32I sequencer
//
// Purpose: groups the decode inputs, memory handshake and all control outputs of
// multicycle_ctrl so the datapath and the controller connect through one port.
// Ports (signals):
//   op[6:0], f3[2:0], f7       instruction fields from the IR
//   zero                       ALU zero flag
//   mem_ready                  memory finished its access this cycle
//   pc_write, ir_write         PC / IR+oldPC load enables
//   mem_write, reg_write       data memory strobe / register file write enable
//   adr_src, res_src[1:0]      memory address mux / result mux
//   alu_control[2:0]           ALU operation
//   alu_src_a[1:0], alu_src_b[1:0], imm_src[1:0]   ALU operand and immediate selects
//   illegal                    unsupported opcode pulse in DECODE
//   state_dbg[3:0]             current sequencer state
// Modports: master = datapath side, slave = controller side.
interface multicycle_ctrl_if;
  logic [6:0] op;
  logic [2:0] f3;
  logic       f7;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] res_src;
  logic [2:0] alu_control;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] imm_src;
  logic       reg_write;
  logic       illegal;
  logic [3:0] state_dbg;

  modport master (
    output op, f3, f7, zero, mem_ready,
    input  pc_write, adr_src, mem_write, ir_write, res_src, alu_control,
           alu_src_a, alu_src_b, imm_src, reg_write, illegal, state_dbg
  );

  modport slave (
    input  op, f3, f7, zero, mem_ready,
    output pc_write, adr_src, mem_write, ir_write, res_src, alu_control,
           alu_src_a, alu_src_b, imm_src, reg_write, illegal, state_dbg
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - sequencing control FSM for the multicycle RV32I core
//
// Purpose: steps the shared PC/ALU/memory datapath through FETCH..WRITEBACK for
// lw, sw, R-type, I-type ALU, beq and jal; stalls on mem_ready.
// Parameters: MEM_HANDSHAKE - 1: FETCH/MEMREAD/MEMWRITE wait for mem_ready,
//             0: mem_ready is treated as always 1.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    multicycle_ctrl_if.slave (decode inputs, handshake, control outputs)
module multicycle_ctrl #(
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  multicycle_ctrl_if.slave bus
);

  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3, MEMWB = 4'd4,
    MEMWRITE = 4'd5, EXECR = 4'd6, EXECI = 4'd7, ALUWB = 4'd8, BEQ = 4'd9,
    JAL = 4'd10
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       adr_src;
    logic [1:0] res_src;
    logic [2:0] alu_control;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
  } ctl_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam ctl_t FETCH_CTL = '{pc_write: 1'b1, ir_write: 1'b1, mem_write: 1'b0,
                                 reg_write: 1'b0, adr_src: 1'b0, res_src: 2'b10,
                                 alu_control: 3'b000, alu_src_a: 2'b00,
                                 alu_src_b: 2'b10};

  state_t state;
  state_t nxt;
  ctl_t   ctl_q;
  logic   rdy;
  logic   pc_gate;
  logic [1:0] imm_sel;

  function automatic logic [2:0] alu_dec(input logic [6:0] op, input logic [2:0] f3,
                                         input logic f7);
    case (f3)
      3'b000:  alu_dec = (op[5] & f7) ? 3'b001 : 3'b000;
      3'b010:  alu_dec = 3'b101;
      3'b110:  alu_dec = 3'b011;
      3'b111:  alu_dec = 3'b010;
      default: alu_dec = 3'b000;
    endcase
  endfunction

  function automatic state_t next_state(input state_t s, input logic [6:0] op,
                                        input logic r);
    case (s)
      FETCH:    next_state = r ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_R:         next_state = EXECR;
          OP_I:         next_state = EXECI;
          OP_BEQ:       next_state = BEQ;
          OP_JAL:       next_state = JAL;
          default:      next_state = FETCH;
        endcase
      end
      MEMADR:   next_state = op[5] ? MEMWRITE : MEMREAD;
      MEMREAD:  next_state = r ? MEMWB : MEMREAD;
      MEMWRITE: next_state = r ? FETCH : MEMWRITE;
      EXECR:    next_state = ALUWB;
      EXECI:    next_state = ALUWB;
      JAL:      next_state = ALUWB;
      default:  next_state = FETCH;
    endcase
  endfunction

  // Moore control word for a state. The IR is stable from DECODE onward, so
  // decoding f3/f7 when entering EXECR/EXECI sees the current instruction.
  function automatic ctl_t ctl_for(input state_t s, input logic [6:0] op,
                                   input logic [2:0] f3, input logic f7);
    ctl_t c;
    c = '0;
    case (s)
      FETCH:    c = FETCH_CTL;
      DECODE:   begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
      MEMADR:   begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
      MEMREAD:  c.adr_src = 1'b1;
      MEMWB:    begin c.res_src = 2'b01; c.reg_write = 1'b1; end
      MEMWRITE: begin c.adr_src = 1'b1; c.mem_write = 1'b1; end
      EXECR:    begin c.alu_src_a = 2'b10; c.alu_control = alu_dec(op, f3, f7); end
      EXECI: begin
        c.alu_src_a   = 2'b10;
        c.alu_src_b   = 2'b01;
        c.alu_control = alu_dec(op, f3, f7);
      end
      ALUWB:    c.reg_write = 1'b1;
      BEQ: begin
        c.alu_src_a   = 2'b10;
        c.alu_control = 3'b001;
        c.pc_write    = 1'b1;
      end
      JAL: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b10;
        c.pc_write  = 1'b1;
      end
      default:  c = '0;
    endcase
    return c;
  endfunction

  assign rdy = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;
  assign nxt = next_state(state, bus.op, rdy);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FETCH;
      ctl_q <= FETCH_CTL;
    end else begin
      state <= nxt;
      ctl_q <= ctl_for(nxt, bus.op, bus.f3, bus.f7);
    end
  end

  // The only combinational dependencies: mem_ready gates FETCH loads, zero gates
  // the branch, and the IR that DECODE sees was loaded on the previous edge.
  always_comb begin
    pc_gate = 1'b1;
    if (state == FETCH) pc_gate = rdy;
    else if (state == BEQ) pc_gate = bus.zero;
  end

  always_comb begin
    imm_sel = 2'b00;
    if (state == DECODE) begin
      case (bus.op)
        OP_SW:   imm_sel = 2'b01;
        OP_BEQ:  imm_sel = 2'b10;
        OP_JAL:  imm_sel = 2'b11;
        default: imm_sel = 2'b00;
      endcase
    end else if (state == MEMADR) begin
      imm_sel = bus.op[5] ? 2'b01 : 2'b00;
    end
  end

  // While reset is held, every enable is blocked and the selects show FETCH.
  assign bus.pc_write    = rst_n & ctl_q.pc_write & pc_gate;
  assign bus.ir_write    = rst_n & ctl_q.ir_write & rdy;
  assign bus.mem_write   = rst_n & ctl_q.mem_write;
  assign bus.reg_write   = rst_n & ctl_q.reg_write;
  assign bus.adr_src     = rst_n ? ctl_q.adr_src     : FETCH_CTL.adr_src;
  assign bus.res_src     = rst_n ? ctl_q.res_src     : FETCH_CTL.res_src;
  assign bus.alu_control = rst_n ? ctl_q.alu_control : FETCH_CTL.alu_control;
  assign bus.alu_src_a   = rst_n ? ctl_q.alu_src_a   : FETCH_CTL.alu_src_a;
  assign bus.alu_src_b   = rst_n ? ctl_q.alu_src_b   : FETCH_CTL.alu_src_b;
  assign bus.imm_src     = rst_n ? imm_sel : 2'b00;
  assign bus.illegal     = rst_n && (state == DECODE) && (nxt == FETCH);
  assign bus.state_dbg   = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - randomized self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  multicycle_ctrl_if bus ();
  multicycle_ctrl #(.MEM_HANDSHAKE(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic bit supported(input logic [6:0] op);
    return op == LW || op == SW || op == RT || op == IT || op == BQ || op == JL;
  endfunction

  // Packed view: {state, pc_w, adr, mem_w, ir_w, res, alu, a, b, imm, reg_w, illegal}
  function automatic logic [20:0] obs_vec();
    return {bus.state_dbg, bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write,
            bus.res_src, bus.alu_control, bus.alu_src_a, bus.alu_src_b, bus.imm_src,
            bus.reg_write, bus.illegal};
  endfunction

  // Expected outputs for a cycle spent in state s, straight from the state table.
  function automatic logic [20:0] exp_vec(input int s, input logic [6:0] op,
                                          input logic [2:0] f3, input logic f7,
                                          input logic mr, input logic z, input logic rn);
    logic pc, adr, mw, ir, rw, ill;
    logic [1:0] res, a, b, imm;
    logic [2:0] alu, dec;
    {pc, adr, mw, ir, rw, ill} = '0;
    {res, a, b, imm} = '0;
    alu = 3'd0;
    if (f3 == 3'b010) dec = 3'd5;
    else if (f3 == 3'b110) dec = 3'd3;
    else if (f3 == 3'b111) dec = 3'd2;
    else if (f3 == 3'b000 && op == RT && f7) dec = 3'd1;
    else dec = 3'd0;
    case (s)
      0: begin b = 2; res = 2; pc = mr; ir = mr; end
      1: begin
        a = 1; b = 1;
        imm = (op == SW) ? 2'd1 : (op == BQ) ? 2'd2 : (op == JL) ? 2'd3 : 2'd0;
        ill = !supported(op);
      end
      2: begin a = 2; b = 1; imm = (op == SW) ? 2'd1 : 2'd0; end
      3: adr = 1;
      4: begin res = 1; rw = 1; end
      5: begin adr = 1; mw = 1; end
      6: begin a = 2; alu = dec; end
      7: begin a = 2; b = 1; alu = dec; end
      8: rw = 1;
      9: begin a = 2; alu = 3'd1; pc = z; end
      10: begin a = 1; b = 2; pc = 1; end
      default: ;
    endcase
    if (!rn) begin
      {pc, adr, mw, ir, rw, ill} = '0;
      a = 0; b = 2; alu = 0; res = 2; imm = 0;
    end
    return {4'(s), pc, adr, mw, ir, res, alu, a, b, imm, rw, ill};
  endfunction

  // Runs one instruction: fs FETCH stalls, ms memory stalls, reset asserted at
  // cycle index rst_at (-1 for none). The state path is laid out from the spec.
  task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input logic z, input int fs, input int ms,
                           input int rst_at);
    int   st_q[$];
    logic mr_q[$];
    int   mw_cnt = 0;
    int   rw_cnt = 0;
    logic mr_cur;
    for (int i = 0; i < fs; i++) begin st_q.push_back(0); mr_q.push_back(1'b0); end
    st_q.push_back(0); mr_q.push_back(1'b1);
    st_q.push_back(1); mr_q.push_back(1'($urandom));
    if (op == LW || op == SW) begin
      st_q.push_back(2); mr_q.push_back(1'($urandom));
      for (int i = 0; i < ms; i++) begin
        st_q.push_back(op == LW ? 3 : 5); mr_q.push_back(1'b0);
      end
      st_q.push_back(op == LW ? 3 : 5); mr_q.push_back(1'b1);
      if (op == LW) begin st_q.push_back(4); mr_q.push_back(1'($urandom)); end
    end else if (op == RT || op == IT) begin
      st_q.push_back(op == RT ? 6 : 7); mr_q.push_back(1'($urandom));
      st_q.push_back(8); mr_q.push_back(1'($urandom));
    end else if (op == BQ) begin
      st_q.push_back(9); mr_q.push_back(1'($urandom));
    end else if (op == JL) begin
      st_q.push_back(10); mr_q.push_back(1'($urandom));
      st_q.push_back(8); mr_q.push_back(1'($urandom));
    end
    for (int k = 0; k < st_q.size(); k++) begin
      @(negedge clk);
      if (k == 0) begin bus.op = op; bus.f3 = f3; bus.f7 = f7; end
      mr_cur = mr_q[k];
      bus.mem_ready = mr_cur;
      bus.zero = (st_q[k] == 9) ? z : 1'($urandom);
      rst_n = (k == rst_at) ? 1'b0 : 1'b1;
      #1;
      check($sformatf("%s_c%0d", name, k), 32'(obs_vec()),
            32'(exp_vec(st_q[k], op, f3, f7, mr_cur, bus.zero, rst_n)));
      mw_cnt += int'(bus.mem_write);
      rw_cnt += int'(bus.reg_write);
      if (k == rst_at) break;
    end
    if (rst_at < 0) begin
      check({name, "_regw_cnt"}, 32'(rw_cnt),
            (op == LW || op == RT || op == IT || op == JL) ? 32'd1 : 32'd0);
      check({name, "_memw_cnt"}, 32'(mw_cnt), (op == SW) ? 32'(ms + 1) : 32'd0);
    end else begin
      check({name, "_rst_regw_cnt"}, 32'(rw_cnt), 32'd0);
    end
  endtask

  initial begin
    logic [6:0] rop;
    bus.op = 7'd0; bus.f3 = 3'd0; bus.f7 = 1'b0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (i == 1) begin
        #1;
        check("reset", 32'(obs_vec()), 32'(exp_vec(0, 7'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0)));
      end
    end
    run_instr("lw", LW, 3'b010, 1'b0, 1'b0, 0, 0, -1);
    run_instr("sw_stall3", SW, 3'b010, 1'b0, 1'b0, 0, 3, -1);
    run_instr("r_sub", RT, 3'b000, 1'b1, 1'b0, 0, 0, -1);
    run_instr("i_add", IT, 3'b000, 1'b1, 1'b0, 0, 0, -1);
    run_instr("beq_taken", BQ, 3'b000, 1'b0, 1'b1, 0, 0, -1);
    run_instr("beq_not", BQ, 3'b000, 1'b0, 1'b0, 0, 0, -1);
    run_instr("jal", JL, 3'b000, 1'b0, 1'b0, 1, 0, -1);
    run_instr("illegal", 7'b1110011, 3'b000, 1'b0, 1'b0, 0, 0, -1);
    run_instr("lw_rst", LW, 3'b010, 1'b0, 1'b0, 0, 2, 3);
    run_instr("after_rst", RT, 3'b111, 1'b0, 1'b0, 0, 0, -1);
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 6))
        0: rop = LW;
        1: rop = SW;
        2: rop = RT;
        3: rop = IT;
        4: rop = BQ;
        5: rop = JL;
        default: begin
          rop = 7'b1110011;
          for (int t = 0; t < 8; t++) begin
            rop = 7'($urandom);
            if (!supported(rop)) break;
            rop = 7'b1110011;
          end
        end
      endcase
      run_instr($sformatf("rnd%0d", n), rop, 3'($urandom), 1'($urandom), 1'($urandom),
                $urandom_range(0, 2), $urandom_range(0, 3), -1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_ready = 1'b0;
    #1;
    check("final_fetch_state", 32'(bus.state_dbg), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
